// File: rtl/buzzer_pkg.sv
// buzzer_pkg: FSM state encoding and default Do..Si half-period dividers for a 125 MHz clock.
package buzzer_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, GAP, KEY} state_t;
  localparam logic [23:0] DIV_DO  = 24'd238_549;
  localparam logic [23:0] DIV_RE  = 24'd212_585;
  localparam logic [23:0] DIV_MI  = 24'd189_393;
  localparam logic [23:0] DIV_FA  = 24'd179_083;
  localparam logic [23:0] DIV_SOL = 24'd159_438;
  localparam logic [23:0] DIV_LA  = 24'd142_045;
  localparam logic [23:0] DIV_SI  = 24'd126_518;
  localparam logic [167:0] DEF_DIV_TABLE = {DIV_SI, DIV_LA, DIV_SOL, DIV_FA, DIV_MI, DIV_RE, DIV_DO};
endpackage

// File: rtl/buzzer_seq_if.sv
// buzzer_seq_if: control inputs and status outputs of the buzzer sequencer.
interface buzzer_seq_if;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic       key_valid;
  logic [3:0] key_idx;
  logic       beep;
  logic       busy;
  logic [3:0] note_idx;
  logic       done;
  modport master (output start, stop, loop_en, key_valid, key_idx, input beep, busy, note_idx, done);
  modport slave (input start, stop, loop_en, key_valid, key_idx, output beep, busy, note_idx, done);
endinterface

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: half-period divider that toggles beep every div+1 enabled cycles.
module buzzer_tone_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  input  logic             clr,
  output logic             beep
);
  logic [DIV_W-1:0] cnt;
  logic tc;
  assign tc = cnt == div;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      beep <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      beep <= 1'b0;
    end else if (en) begin
      cnt  <= tc ? '0 : cnt + DIV_W'(1);
      beep <= beep ^ tc;
    end
endmodule

// File: rtl/buzzer_seq.sv
// buzzer_seq: plays a fixed note table as a square wave, with gaps, looping and a live key mode.
module buzzer_seq import buzzer_pkg::*; #(
  parameter int NOTE_NUM = 7,
  parameter int DIV_W    = 24,
  parameter int DUR_W    = 32,
  parameter int NOTE_DUR = 124_999_999,
  parameter int GAP_DUR  = 0,
  parameter logic [NOTE_NUM*DIV_W-1:0] DIV_TABLE = DEF_DIV_TABLE
) (
  input  logic         clk,
  input  logic         rst,
  buzzer_seq_if.slave  bus
);
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_DUR);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_DUR);
  localparam logic [3:0] NN        = 4'(NOTE_NUM);
  localparam logic [3:0] LAST_NOTE = 4'(NOTE_NUM - 1);
  state_t state, nxt;
  logic [3:0] note_q, note_nxt;
  logic [DUR_W-1:0] dur, dur_nxt;
  logic [DIV_W-1:0] div;
  logic done_q, done_nxt, clr, adv;
  always_comb begin
    nxt      = state;
    note_nxt = note_q;
    dur_nxt  = dur + DUR_W'(1);
    done_nxt = 1'b0;
    clr      = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        dur_nxt  = '0;
        note_nxt = '0;
        clr      = 1'b1;
        if (bus.key_valid && bus.key_idx < NN) begin
          nxt      = KEY;
          note_nxt = bus.key_idx;
        end
      end
      PLAY:
        if (dur == NOTE_LAST) begin
          if (GAP_DUR > 0) begin
            nxt     = GAP;
            dur_nxt = '0;
            clr     = 1'b1;
          end else adv = 1'b1;
        end
      GAP: begin
        clr = 1'b1;
        adv = dur == GAP_LAST;
      end
      KEY: begin
        dur_nxt  = '0;
        note_nxt = bus.key_valid ? bus.key_idx : 4'd0;
        nxt      = bus.key_valid ? KEY : IDLE;
        clr      = !bus.key_valid || bus.key_idx != note_q || bus.key_idx >= NN;
      end
      default: nxt = IDLE;
    endcase
    // the last note either wraps (loop_en sampled here) or ends the run with done
    if (adv) begin
      dur_nxt  = '0;
      clr      = 1'b1;
      nxt      = (note_q < LAST_NOTE || bus.loop_en) ? PLAY : IDLE;
      note_nxt = note_q < LAST_NOTE ? note_q + 4'd1 : 4'd0;
      done_nxt = !(note_q < LAST_NOTE || bus.loop_en);
    end
    if (bus.start || bus.stop) begin
      nxt      = bus.stop ? IDLE : PLAY;
      note_nxt = '0;
      dur_nxt  = '0;
      clr      = 1'b1;
      done_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      note_q <= '0;
      dur    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      note_q <= note_nxt;
      dur    <= dur_nxt;
      done_q <= done_nxt;
    end
  // out-of-range indices select no entry and leave div at 0
  always_comb begin
    div = '0;
    for (int i = 0; i < NOTE_NUM; i++)
      if (note_q == 4'(i)) div = DIV_TABLE[i*DIV_W +: DIV_W];
  end
  buzzer_tone_gen #(.DIV_W(DIV_W)) u_tone (
    .clk  (clk),
    .rst  (rst),
    .div  (div),
    .en   (state == PLAY || state == KEY),
    .clr  (clr),
    .beep (bus.beep)
  );
  assign bus.busy     = state != IDLE;
  assign bus.note_idx = note_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_buzzer_seq.sv
// tb_buzzer_seq: directed checks of playback, looping, key mode, reset and restart on a 3-note table.
module tb_buzzer_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int saw_done;
  buzzer_seq_if bus();
  buzzer_seq #(
    .NOTE_NUM (3),
    .DIV_W    (8),
    .DUR_W    (8),
    .NOTE_DUR (19),
    .GAP_DUR  (4),
    .DIV_TABLE(24'h04_03_02)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  // packed outputs: done[6] busy[5] beep[4] note_idx[3:0]
  function automatic int outs();
    return int'({bus.done, bus.busy, bus.beep, bus.note_idx});
  endfunction
  // non-looping run: 25-cycle slots (20 play + 5 gap), note n half-period n+3
  function automatic int seq_exp(input int c);
    int n, k, b;
    if (c == 75) return 'h40;
    if (c > 75) return 0;
    n = c / 25;
    k = c % 25;
    b = (k < 20) ? (k / (n + 3)) % 2 : 0;
    return 'h20 | (b << 4) | n;
  endfunction
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_idx = 4'd0;
    tick(2);
    chk("reset_hold", outs(), 0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", outs(), 0);
    pulse_start();
    for (int c = 0; c <= 76; c++) begin
      chk($sformatf("seq_c%0d", c), outs(), seq_exp(c));
      tick();
    end
    bus.loop_en = 1'b1;
    pulse_start();
    saw_done = 0;
    for (int c = 0; c <= 105; c++) begin
      if (c % 25 == 0) chk($sformatf("loop_note_c%0d", c), int'(bus.note_idx), (c / 25) % 3);
      saw_done |= int'(bus.done);
      if (c < 105) tick();
    end
    chk("loop_beep_c105", int'(bus.beep), 1);
    chk("loop_no_done", saw_done, 0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    chk("stop_idle", outs(), 0);
    bus.key_idx = 4'd1;
    bus.key_valid = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("key_c%0d", c), outs(), 'h21 | ((((c / 4) % 2)) << 4));
      tick();
    end
    bus.key_idx = 4'd5;
    tick();
    chk("key_inv_beep", int'(bus.beep), 0);
    chk("key_inv_busy", int'(bus.busy), 1);
    tick(3);
    chk("key_inv_hold", int'({bus.busy, bus.beep}), 2);
    bus.key_valid = 1'b0;
    tick();
    chk("key_release", outs(), 0);
    bus.key_valid = 1'b1;
    tick(2);
    chk("key_invalid_from_idle", outs(), 0);
    bus.key_valid = 1'b0;
    pulse_start();
    tick(30);
    chk("pre_rst_note1", outs(), 'h31);
    rst = 1'b1;
    #1;
    chk("rst_async", outs(), 0);
    tick(3);
    chk("rst_held", outs(), 0);
    rst = 1'b0;
    tick(3);
    chk("rst_released_wait", outs(), 0);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk("start_stop_same", outs(), 0);
    tick();
    chk("start_stop_after", outs(), 0);
    pulse_start();
    tick(55);
    chk("pre_restart_note2", outs(), 'h32);
    pulse_start();
    chk("restart_c0", outs(), 'h20);
    tick();
    chk("restart_c1", outs(), 'h20);
    tick();
    chk("restart_c2", outs(), 'h20);
    tick();
    chk("restart_c3", outs(), 'h30);
    tick(21);
    chk("restart_c24_gap", outs(), 'h20);
    tick();
    chk("restart_c25_note1", outs(), 'h21);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("final_stop", outs(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/buzzer_seq.md
BUZZER_SEQ -- requirements
Module: buzzer_seq

Interface
REQ-001 Parameter NOTE_NUM, default 7: number of notes in the sequence, range 1..15.
REQ-002 Parameter DIV_W, default 24: width of the half-period divider values.
REQ-003 Parameter DUR_W, default 32: width of the duration counter.
REQ-004 Parameter NOTE_DUR, default 124_999_999: clock cycles per note, minus 1.
REQ-005 Parameter GAP_DUR, default 0: silent cycles between notes; 0 means no gap.
REQ-006 Parameter DIV_TABLE, default buzzer_pkg Do..Si values: NOTE_NUM*DIV_W flat vector; entry i is note i half-period minus 1, and entry 0 is the LSB slice.
REQ-007 clk  input  1  system clock; the only clock.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  one-cycle pulse that (re)starts the sequence from note 0.
REQ-010 stop  input  1  one-cycle pulse that aborts playback.
REQ-011 loop_en  input  1  when 1, the sequence wraps to note 0 after the last note instead of ending.
REQ-012 key_valid  input  1  level; while 1 in IDLE, note key_idx sounds continuously.
REQ-013 key_idx  input  4  note index for key mode; values >= NOTE_NUM are ignored (silent).
REQ-014 beep  output  1  square-wave buzzer drive.
REQ-015 busy  output  1  1 in any state other than IDLE.
REQ-016 note_idx  output  4  index of the current note; 0 in IDLE.
REQ-017 done  output  1  one-cycle pulse at the end of a non-looping sequence.

Function
REQ-018 FSM states: IDLE, PLAY, GAP, KEY.
REQ-019 IDLE->PLAY on start, with note_idx=0 and duration counter=0; start has priority over key_valid.
REQ-020 IDLE->KEY when key_valid=1 and key_idx<NOTE_NUM; KEY->IDLE the cycle after key_valid falls.
REQ-021 PLAY: duration counter counts 0..NOTE_DUR; at NOTE_DUR go to GAP if GAP_DUR>0, else advance to the next note.
REQ-022 GAP: beep=0 for GAP_DUR cycles, then advance to the next note.
REQ-023 Advance: if note_idx<NOTE_NUM-1, increment; at the last note with loop_en=1, wrap to 0; otherwise go to IDLE with done=1 for that one cycle.
REQ-024 loop_en is sampled at each note advance, not latched at start.
REQ-025 Tone: divider counts 0..DIV_TABLE[note_idx]; at terminal count it toggles beep and clears, giving a period of 2*(DIV+1) cycles.
REQ-026 On every note change, state entry, and in IDLE/GAP: divider=0 and beep=0.
REQ-027 stop in any state: next state IDLE, all counters cleared, beep=0, done not asserted; stop has priority over start in the same cycle.
REQ-028 start while in PLAY/GAP/KEY: restart at note 0 of PLAY.
REQ-029 key_idx changing while in KEY: the divider restarts on the new note; a change to an invalid key_idx gives beep=0 with the state held.
REQ-030 All outputs are registered; beep starts toggling DIV+1 cycles after entering PLAY.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, all counters=0, beep=0, busy=0, note_idx=0, done=0.
REQ-032 rst asserted mid-note aborts immediately with no done pulse; after release, the block waits for start or key_valid.

Structure
REQ-033 buzzer_pkg (shared include) holds the state encodings and the default Do..Si divider constants for 125 MHz: 238_549, 212_585, 189_393, 179_083, 159_438, 142_045, 126_518.
REQ-034 The single sub-module buzzer_tone_gen (divider counter + beep toggle, inputs div/en/clr) is instantiated once.
REQ-035 The DIV_TABLE slice is selected by note_idx (or key_idx in KEY); counter widths follow DIV_W and DUR_W.

Verification
(All scenarios use NOTE_NUM=3, NOTE_DUR=19, GAP_DUR=4, DIV_TABLE={4,3,2} for notes 2,1,0.)
REQ-036 start, loop_en=0 -> note0 beep period 6 cycles, note1 8, note2 10; 20 cycles each, 5-cycle silent gaps between notes; done pulses once; busy falls together with the done cycle.
REQ-037 start, loop_en=1 -> note_idx sequence 0,1,2,0,1 with no done; stop -> beep=0 and IDLE the next cycle.
REQ-038 key_valid=1, key_idx=1 for 40 cycles -> beep period 8, busy=1; key_idx=5 -> beep=0; key_valid=0 -> IDLE.
REQ-039 rst pulsed mid-note1 -> all outputs 0 during reset with no done pulse; start and stop in the same cycle -> remains IDLE.
REQ-040 start pulsed again during note2 -> note_idx=0 and duration restarts at 0; beep=0 until the first toggle 3 cycles later.
